// File: rtl/seq_pkg.sv
// Shared definitions for the sequential scan arbiter: detector state codes,
// controller state codes and the default scanned word width.
package seq_pkg;

   localparam int W_DEFAULT = 8;

   typedef enum logic [1:0] {
      DET_A = 2'd0,
      DET_B = 2'd1,
      DET_C = 2'd2,
      DET_D = 2'd3
   } det_state_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } ctl_state_e;

endpackage

// File: rtl/seq1001_det.sv
// Mealy recognizer for the bit pattern "1001", overlapping matches allowed.
// Ports:
//   clock  rising-edge clock
//   reset  asynchronous active-low reset (state -> A)
//   clear  synchronous return to A, wins over en
//   en     advance on x this cycle
//   x      serial input bit
//   z      high for the cycle in which the final '1' of "1001" is presented
//
// state | meaning
// A     | nothing useful seen
// B     | last bit was 1
// C     | seen "10"
// D     | seen "100"
module seq1001_det
   import seq_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic en,
   input  logic x,
   output logic z
);

   det_state_e state_q, state_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= DET_A;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      z       = 1'b0;
      if (clear) begin
         state_d = DET_A;
      end else if (en) begin
         case (state_q)
            DET_A: state_d = x ? DET_B : DET_A;
            DET_B: state_d = x ? DET_B : DET_C;
            DET_C: state_d = x ? DET_B : DET_D;
            DET_D: begin
               // Completing "1001" leaves the trailing 1 as the start of the next match.
               state_d = x ? DET_B : DET_A;
               z       = x;
            end
            default: state_d = DET_A;
         endcase
      end
   end

endmodule

// File: rtl/seq_scan_arbiter.sv
// Two-requester round-robin arbiter that serially scans the granted word
// MSB first through a "1001" detector and reports the match count.
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-low reset
//   req[1:0]   scan request per requester
//   data0/1    requester words, sampled in the grant cycle only
//   gnt[1:0]   one-hot grant, held from first SCAN cycle through DONE
//   busy       high in SCAN and DONE
//   z          raw detector output for the bit being scanned
//   done       one-cycle result-valid pulse
//   done_id    requester owning the value on match_cnt
//   match_cnt  number of "1001" occurrences in the scanned word
//
// state | meaning
// IDLE  | waiting for a request, results held
// SCAN  | shifting W bits into the detector, one per cycle
// DONE  | result valid for one cycle
module seq_scan_arbiter
   import seq_pkg::*;
#(
   parameter int W  = W_DEFAULT,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [1:0]    req,
   input  logic [W-1:0]  data0,
   input  logic [W-1:0]  data1,
   output logic [1:0]    gnt,
   output logic          busy,
   output logic          z,
   output logic          done,
   output logic          done_id,
   output logic [CW-1:0] match_cnt
);

   ctl_state_e    state_q, state_d;
   logic [1:0]    gnt_q, gnt_d;
   logic [W-1:0]  shreg_q, shreg_d;
   logic [CW-1:0] bit_cnt_q, bit_cnt_d;
   logic [CW-1:0] match_cnt_q, match_cnt_d;
   logic          done_id_q, done_id_d;
   logic          prio_q, prio_d;   // requester favoured on a tie
   logic          pick;
   logic          det_clear, det_en, det_z;

   seq1001_det u_det (
      .clock (clock),
      .reset (reset),
      .clear (det_clear),
      .en    (det_en),
      .x     (shreg_q[W-1]),
      .z     (det_z)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         gnt_q       <= 2'b00;
         shreg_q     <= '0;
         bit_cnt_q   <= '0;
         match_cnt_q <= '0;
         done_id_q   <= 1'b0;
         prio_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         shreg_q     <= shreg_d;
         bit_cnt_q   <= bit_cnt_d;
         match_cnt_q <= match_cnt_d;
         done_id_q   <= done_id_d;
         prio_q      <= prio_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      shreg_d     = shreg_q;
      bit_cnt_d   = bit_cnt_q;
      match_cnt_d = match_cnt_q;
      done_id_d   = done_id_q;
      prio_d      = prio_q;
      pick        = 1'b0;
      det_clear   = 1'b0;
      det_en      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req != 2'b00) begin
               // Tie goes to the pointer; a lone requester wins outright.
               pick        = (req == 2'b11) ? prio_q : req[1];
               gnt_d       = pick ? 2'b10 : 2'b01;
               shreg_d     = pick ? data1 : data0;
               bit_cnt_d   = CW'(W - 1);
               match_cnt_d = '0;
               done_id_d   = pick;
               prio_d      = ~pick;
               det_clear   = 1'b1;
               state_d     = ST_SCAN;
            end
         end
         ST_SCAN: begin
            det_en      = 1'b1;
            shreg_d     = {shreg_q[W-2:0], 1'b0};
            match_cnt_d = match_cnt_q + CW'(det_z);
            if (bit_cnt_q == '0) state_d = ST_DONE;
            else                 bit_cnt_d = bit_cnt_q - CW'(1);
         end
         ST_DONE: begin
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = 2'b00;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign gnt       = gnt_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign done_id   = done_id_q;
   assign match_cnt = match_cnt_q;
   assign z         = det_z;

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Directed bench for seq_scan_arbiter: reset values, round-robin order,
// match counting with overlap, word isolation, req drop mid-scan and
// asynchronous reset mid-scan.
module tb_seq_scan_arbiter;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clock;
   logic          reset;
   logic [1:0]    req;
   logic [W-1:0]  data0;
   logic [W-1:0]  data1;
   logic [1:0]    gnt;
   logic          busy;
   logic          z;
   logic          done;
   logic          done_id;
   logic [CW-1:0] match_cnt;

   int n_checks = 0;
   int n_errors = 0;

   seq_scan_arbiter #(.W(W), .CW(CW)) dut (
      .clock     (clock),
      .reset     (reset),
      .req       (req),
      .data0     (data0),
      .data1     (data1),
      .gnt       (gnt),
      .busy      (busy),
      .z         (z),
      .done      (done),
      .done_id   (done_id),
      .match_cnt (match_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Issue a request at a falling edge and follow the scan to its end.
   task automatic run_word(input string tag, input logic [1:0] req_v, input logic [1:0] req_after,
                           input logic [W-1:0] d0, input logic [W-1:0] d1,
                           input logic [1:0] exp_gnt, input int exp_cnt, input logic exp_id);
      int n;
      int zc;
      req   = req_v;
      data0 = d0;
      data1 = d1;
      @(negedge clock);
      n  = 1;
      zc = int'(z);
      chk({tag, " gnt"}, 32'(gnt), 32'(exp_gnt));
      chk({tag, " busy"}, 32'(busy), 32'd1);
      chk({tag, " early done"}, 32'(done), 32'd0);
      req   = req_after;
      data0 = ~d0;
      data1 = ~d1;
      while (!done && n < W + 4) begin
         @(negedge clock);
         n++;
         if (!done) zc += int'(z);
      end
      chk({tag, " latency"}, 32'(n), 32'(W + 1));
      chk({tag, " match_cnt"}, 32'(match_cnt), 32'(exp_cnt));
      chk({tag, " done_id"}, 32'(done_id), 32'(exp_id));
      chk({tag, " gnt in done"}, 32'(gnt), 32'(exp_gnt));
      chk({tag, " z pulses"}, 32'(zc), 32'(exp_cnt));
      @(negedge clock);
      chk({tag, " idle done"}, 32'(done), 32'd0);
      chk({tag, " idle gnt"}, 32'(gnt), 32'd0);
      chk({tag, " idle busy"}, 32'(busy), 32'd0);
      chk({tag, " idle z"}, 32'(z), 32'd0);
      chk({tag, " held cnt"}, 32'(match_cnt), 32'(exp_cnt));
      chk({tag, " held id"}, 32'(done_id), 32'(exp_id));
   endtask

   initial begin
      int pulses;
      reset = 1'b0;
      req   = 2'b11;
      data0 = 8'hFF;
      data1 = 8'hFF;
      #3;
      chk("rst gnt", 32'(gnt), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst z", 32'(z), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst done_id", 32'(done_id), 32'd0);
      chk("rst match_cnt", 32'(match_cnt), 32'd0);
      repeat (2) @(negedge clock);
      req   = 2'b00;
      reset = 1'b1;
      @(negedge clock);
      chk("idle busy", 32'(busy), 32'd0);

      // Round robin with both requests held.
      run_word("rr1", 2'b11, 2'b11, 8'b1001_1001, 8'b1001_0000, 2'b01, 2, 1'b0);
      run_word("rr2", 2'b11, 2'b11, 8'b1001_1001, 8'b1001_0000, 2'b10, 1, 1'b1);
      run_word("rr3", 2'b11, 2'b11, 8'b1001_1001, 8'b1001_0000, 2'b01, 2, 1'b0);

      // Lone requester 0 while the pointer favours 1; req dropped during scan.
      run_word("r0drop", 2'b01, 2'b00, 8'b1001_0000, 8'b1111_1111, 2'b01, 1, 1'b0);
      run_word("r1a", 2'b10, 2'b00, 8'b0000_0000, 8'b1001_1001, 2'b10, 2, 1'b1);
      run_word("r1ovl", 2'b10, 2'b00, 8'b0000_0000, 8'b1001_0010, 2'b10, 2, 1'b1);

      // Word isolation: first word leaves "100", second begins with 1.
      run_word("iso1", 2'b01, 2'b00, 8'b0000_0100, 8'b1001_1001, 2'b01, 0, 1'b0);
      run_word("iso2", 2'b01, 2'b00, 8'b1000_0000, 8'b1001_1001, 2'b01, 0, 1'b0);

      // Asynchronous reset during the 4th scan cycle.
      run_word("pre", 2'b10, 2'b00, 8'b0000_0000, 8'b1001_1001, 2'b10, 2, 1'b1);
      req   = 2'b01;
      data0 = 8'b1001_1001;
      @(negedge clock);
      req = 2'b00;
      repeat (3) @(negedge clock);
      chk("mid busy", 32'(busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      chk("arst gnt", 32'(gnt), 32'd0);
      chk("arst busy", 32'(busy), 32'd0);
      chk("arst match_cnt", 32'(match_cnt), 32'd0);
      chk("arst done_id", 32'(done_id), 32'd0);
      chk("arst done", 32'(done), 32'd0);
      @(negedge clock);
      reset  = 1'b1;
      pulses = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clock);
         pulses += int'(done);
      end
      chk("arst no done", 32'(pulses), 32'd0);
      chk("arst idle", 32'(busy), 32'd0);

      // Normal operation after the mid-scan reset; pointer back to requester 0.
      run_word("post", 2'b11, 2'b00, 8'b1001_0000, 8'b1001_1001, 2'b01, 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
